// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the CPU memory responder slice.
package cpu_mem_pkg;

  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = 16;
  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccessDone
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the MAR/MDR side and the memory responder.
interface mem_responder_if #(
  parameter int unsigned AW = cpu_mem_pkg::AW,
  parameter int unsigned DW = cpu_mem_pkg::DW
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          err;
  logic          busy;

  modport master (
    output req, we, addr_in, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr_in, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port DEPTH x DW store: synchronous write, registered synchronous read.
module mem_array #(
  parameter int unsigned AW    = cpu_mem_pkg::AW,
  parameter int unsigned DW    = cpu_mem_pkg::DW,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]   store [DEPTH];
  logic [IdxW-1:0] idx;

  assign idx = addr[IdxW-1:0];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (en && we) begin
      store[idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (en && !we) begin
      dout <= store[idx];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a request, waits WAIT_CYCLES, then performs one access.
module mem_responder #(
  parameter int unsigned AW          = cpu_mem_pkg::AW,
  parameter int unsigned DW          = cpu_mem_pkg::DW,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);
  import cpu_mem_pkg::*;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic                we_q;
  logic                err_q;
  logic                capture;
  logic                go;

  logic [AW-1:0]       acc_addr;
  logic [DW-1:0]       acc_wdata;
  logic                acc_we;
  logic [31:0]         addr_ext;
  logic                in_range;
  logic                mem_en;
  logic [DW-1:0]       mem_dout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    go      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = StAccessDone;
            go      = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WCNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StAccessDone;
          go      = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAccessDone: state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= go & ~in_range;
      if (capture) begin
        addr_q  <= bus.addr_in;
        wdata_q <= bus.wdata;
        we_q    <= bus.we;
      end
    end
  end

  // With zero wait states the access happens on the capture edge itself.
  assign acc_addr  = (state_q == StIdle) ? bus.addr_in : addr_q;
  assign acc_wdata = (state_q == StIdle) ? bus.wdata   : wdata_q;
  assign acc_we    = (state_q == StIdle) ? bus.we      : we_q;

  assign addr_ext = 32'(acc_addr);
  assign in_range = addr_ext < DEPTH;
  // Gating on rst keeps a write from landing while reset is asserted.
  assign mem_en   = go & in_range & rst;

  mem_array #(
    .AW   (AW),
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_mem_array (
    .clk (clk),
    .rst (rst),
    .en  (mem_en),
    .we  (acc_we),
    .addr(acc_addr),
    .din (acc_wdata),
    .dout(mem_dout)
  );

  assign bus.rdata = mem_dout;
  assign bus.ack   = (state_q == StAccessDone);
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != StIdle);
endmodule

// File: tb/tb_mem_responder.sv
// Directed plus random checks of mem_responder against an array-based reference model.
module tb_mem_responder;

  localparam int unsigned WC  [3] = '{2, 0, 2};
  localparam int unsigned DEP [3] = '{256, 256, 128};

  logic clk;
  logic rst;

  mem_responder_if #(.AW(8), .DW(16)) b0 ();
  mem_responder_if #(.AW(8), .DW(16)) b1 ();
  mem_responder_if #(.AW(8), .DW(16)) b2 ();

  mem_responder #(.AW(8), .DW(16), .DEPTH(256), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  mem_responder #(.AW(8), .DW(16), .DEPTH(256), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  mem_responder #(.AW(8), .DW(16), .DEPTH(128), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_mem [3][256];
  bit          model_ok  [3][256];
  logic [15:0] exp_rd    [3];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(int sel, logic rq, logic w, logic [7:0] a, logic [15:0] d);
    case (sel)
      0:       begin b0.req = rq; b0.we = w; b0.addr_in = a; b0.wdata = d; end
      1:       begin b1.req = rq; b1.we = w; b1.addr_in = a; b1.wdata = d; end
      default: begin b2.req = rq; b2.we = w; b2.addr_in = a; b2.wdata = d; end
    endcase
  endtask

  task automatic get_out(int sel, output logic [15:0] rd, output logic ak,
                         output logic er, output logic bz);
    case (sel)
      0:       begin rd = b0.rdata; ak = b0.ack; er = b0.err; bz = b0.busy; end
      1:       begin rd = b1.rdata; ak = b1.ack; er = b1.err; bz = b1.busy; end
      default: begin rd = b2.rdata; ak = b2.ack; er = b2.err; bz = b2.busy; end
    endcase
  endtask

  task automatic check_idle_zero(string tag, int sel);
    logic [15:0] rd;
    logic        ak, er, bz;
    get_out(sel, rd, ak, er, bz);
    check({tag, " ack"}, ak, 0);
    check({tag, " busy"}, bz, 0);
    check({tag, " err"}, er, 0);
    check({tag, " rdata"}, rd, 0);
  endtask

  // One transaction starting at a negedge; inputs are scrambled after capture.
  task automatic run_txn(string tag, int sel, logic w, logic [7:0] a, logic [15:0] d,
                         logic [7:0] alt);
    logic [15:0] rd;
    logic        ak, er, bz;
    bit          exp_err;
    exp_err = (int'(a) >= int'(DEP[sel]));
    set_in(sel, 1'b1, w, a, d);
    @(posedge clk);
    #1 set_in(sel, 1'b0, ~w, alt, ~d);
    for (int k = 0; k < int'(WC[sel]); k++) begin
      @(negedge clk);
      get_out(sel, rd, ak, er, bz);
      check({tag, " early ack"}, ak, 0);
      check({tag, " busy in wait"}, bz, 1);
      @(posedge clk);
    end
    if (!exp_err) begin
      if (w) begin
        model_mem[sel][a] = d;
        model_ok[sel][a]  = 1'b1;
      end else begin
        exp_rd[sel] = model_mem[sel][a];
      end
    end
    @(negedge clk);
    get_out(sel, rd, ak, er, bz);
    check({tag, " ack"}, ak, 1);
    check({tag, " err"}, er, exp_err);
    check({tag, " rdata"}, rd, exp_rd[sel]);
    check({tag, " busy at ack"}, bz, 1);
    @(posedge clk);
    @(negedge clk);
    get_out(sel, rd, ak, er, bz);
    check({tag, " ack drop"}, ak, 0);
    check({tag, " busy drop"}, bz, 0);
    check({tag, " err drop"}, er, 0);
    check({tag, " rdata hold"}, rd, exp_rd[sel]);
  endtask

  initial begin
    logic [15:0] rd;
    logic        ak, er, bz;
    int          n_ack;
    int          ack_cyc [3];
    int          sel;
    logic        w;
    logic [7:0]  a;

    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_in(s, 1'b0, 1'b0, 8'h00, 16'h0000);
      exp_rd[s] = 16'h0000;
      for (int i = 0; i < 256; i++) model_ok[s][i] = 1'b0;
    end
    #3;
    for (int s = 0; s < 3; s++) check_idle_zero("reset", s);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_txn("wr beef", 0, 1'b1, 8'h3C, 16'hBEEF, 8'hC3);
    run_txn("rd beef", 0, 1'b0, 8'h3C, 16'h0000, 8'hC3);

    // Asynchronous reset well away from any clock edge.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_idle_zero("async rst", 0);
    @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < 3; s++) exp_rd[s] = 16'h0000;

    run_txn("w0 wr", 1, 1'b1, 8'h20, 16'h1234, 8'h21);
    run_txn("w0 rd", 1, 1'b0, 8'h20, 16'h0000, 8'h21);

    run_txn("pre 10", 0, 1'b1, 8'd10, 16'hA010, 8'h00);
    run_txn("pre 11", 0, 1'b1, 8'd11, 16'hA011, 8'h00);
    run_txn("pre 12", 0, 1'b1, 8'd12, 16'hA012, 8'h00);

    // req held high: captures at 10, 11, 12 in turn.
    set_in(0, 1'b1, 1'b0, 8'd10, 16'h0000);
    n_ack = 0;
    for (int c = 0; c < 30 && n_ack < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      get_out(0, rd, ak, er, bz);
      if (ak) begin
        ack_cyc[n_ack] = c;
        check("held rdata", rd, model_mem[0][10 + n_ack]);
        check("held err", er, 0);
        n_ack++;
      end
      if (n_ack == 3) set_in(0, 1'b0, 1'b0, 8'd12, 16'h0000);
      else set_in(0, 1'b1, 1'b0, 8'(10 + (((c + 1) / 4) > 2 ? 2 : (c + 1) / 4)), 16'h0000);
    end
    check("held ack count", n_ack, 3);
    if (n_ack == 3) begin
      check("held first ack", ack_cyc[0], WC[0]);
      check("held spacing 1", ack_cyc[1] - ack_cyc[0], WC[0] + 2);
      check("held spacing 2", ack_cyc[2] - ack_cyc[1], WC[0] + 2);
    end
    exp_rd[0] = model_mem[0][12];
    @(posedge clk);
    @(negedge clk);
    get_out(0, rd, ak, er, bz);
    check("held idle busy", bz, 0);

    run_txn("wr 10", 0, 1'b1, 8'h10, 16'h1111, 8'h11);
    run_txn("wr 11", 0, 1'b1, 8'h11, 16'h2222, 8'h10);
    run_txn("rd 10 alt 11", 0, 1'b0, 8'h10, 16'h0000, 8'h11);
    run_txn("rd 11 intact", 0, 1'b0, 8'h11, 16'h0000, 8'h10);

    run_txn("rng wr 00", 2, 1'b1, 8'h00, 16'h0F0F, 8'h80);
    run_txn("rng wr 7f", 2, 1'b1, 8'h7F, 16'h7777, 8'h80);
    run_txn("rng rd 7f", 2, 1'b0, 8'h7F, 16'h0000, 8'h80);
    run_txn("rng wr 80", 2, 1'b1, 8'h80, 16'hDEAD, 8'h00);
    run_txn("rng rd 80", 2, 1'b0, 8'h80, 16'h0000, 8'h00);
    run_txn("rng rd 00", 2, 1'b0, 8'h00, 16'h0000, 8'h80);

    // Reset during the wait of a write: no ack, old contents survive.
    run_txn("old 05", 0, 1'b1, 8'h05, 16'h0A0A, 8'h00);
    set_in(0, 1'b1, 1'b1, 8'h05, 16'h5555);
    @(posedge clk);
    #1 set_in(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1 check_idle_zero("midop rst", 0);
    @(posedge clk);
    @(negedge clk);
    get_out(0, rd, ak, er, bz);
    check("midop no ack", ak, 0);
    rst = 1'b1;
    for (int s = 0; s < 3; s++) exp_rd[s] = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      get_out(0, rd, ak, er, bz);
      check("midop post ack", ak, 0);
      check("midop post busy", bz, 0);
    end
    run_txn("rd 05 old", 0, 1'b0, 8'h05, 16'h0000, 8'h06);

    for (int i = 0; i < 36; i++) begin
      sel = int'($urandom_range(0, 2));
      w   = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(120, 135));
      if (!w && int'(a) < int'(DEP[sel]) && !model_ok[sel][a]) w = 1'b1;
      run_txn("rand", sel, w, a, 16'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
